// File: rtl/rename_register_file_pkg.sv
// Shared constants for the rename register file.
//   ROB_ADDR_W : width of a reorder-buffer id tag
//   ROB_SIZE   : number of reorder-buffer entries (2**ROB_ADDR_W)
//   REG_NUM    : architectural register count, x0 hard-wired to zero
//   REG_IDX_W  : width of an architectural register index
//   XLEN       : datapath width
package rename_register_file_pkg;
    localparam int ROB_ADDR_W = 4;
    localparam int ROB_SIZE   = 1 << ROB_ADDR_W;
    localparam int REG_NUM    = 32;
    localparam int REG_IDX_W  = 5;
    localparam int XLEN       = 32;
endpackage

// File: rtl/rename_register_file_rf_read_port.sv
// One source-operand read port of the rename register file.
// Resolves the selected register's stored state into value/busy/dep, and
// bypasses a same-cycle commit whose tag still owns the register so the
// Decoder never waits a cycle for a result that is retiring right now.
// Ports:
//   rs_i           : register index being read
//   reg_value_i    : stored value of that register
//   reg_busy_i     : stored busy flag of that register
//   reg_dep_i      : stored producer tag of that register
//   commit_*_i     : retirement from the reorder buffer this cycle
//   clear_i        : flush this cycle (suppresses the bypass)
//   value_o/busy_o/dep_o : resolved operand
module rf_read_port
    import rename_register_file_pkg::*;
#(
    parameter int P_XLEN       = XLEN,
    parameter int P_ROB_ADDR_W = ROB_ADDR_W
) (
    input  logic [REG_IDX_W-1:0]    rs_i,
    input  logic [P_XLEN-1:0]       reg_value_i,
    input  logic                    reg_busy_i,
    input  logic [P_ROB_ADDR_W-1:0] reg_dep_i,
    input  logic                    commit_i,
    input  logic                    clear_i,
    input  logic [REG_IDX_W-1:0]    commit_rd_i,
    input  logic [P_ROB_ADDR_W-1:0] commit_robid_i,
    input  logic [P_XLEN-1:0]       commit_value_i,
    output logic [P_XLEN-1:0]       value_o,
    output logic                    busy_o,
    output logic [P_ROB_ADDR_W-1:0] dep_o
);
    logic bypass;

    // Forward only when the retiring instruction is the register's current
    // owner; a stale tag means a younger writer is still in flight.
    assign bypass = commit_i && !clear_i && (rs_i == commit_rd_i) &&
                    reg_busy_i && (reg_dep_i == commit_robid_i);

    always_comb begin
        value_o = '0;
        busy_o  = 1'b0;
        dep_o   = '0;
        if (rs_i != '0) begin
            if (bypass) begin
                value_o = commit_value_i;
            end else if (reg_busy_i) begin
                busy_o = 1'b1;
                dep_o  = reg_dep_i;
            end else begin
                value_o = reg_value_i;
            end
        end
    end
endmodule

// File: rtl/rename_register_file.sv
// Architectural register file with per-register rename tags.
// Each register holds a value, a busy flag and the RoB id of its youngest
// in-flight writer. Issue claims a register, commit retires a value and
// releases the claim only if the tag still matches, flush drops all claims.
// Ports:
//   clk_in, rst_in, rdy_in : clock, synchronous reset, global enable
//   clear_in               : mispredict flush
//   issue_in/_rd/_dep      : new in-flight writer allocation
//   commit_in/_rd/_robid/_value : head-of-RoB retirement
//   dc_rs1, dc_rs2         : Decoder source indices
//   rsN_value/_busy/_dep   : combinational operand answers
module rename_register_file
    import rename_register_file_pkg::*;
#(
    parameter int P_ROB_ADDR_W = ROB_ADDR_W,
    parameter int P_XLEN       = XLEN,
    parameter int NUM_REGS     = REG_NUM
) (
    input  logic                    clk_in,
    input  logic                    rst_in,
    input  logic                    rdy_in,
    input  logic                    clear_in,
    input  logic                    issue_in,
    input  logic [REG_IDX_W-1:0]    issue_rd,
    input  logic [P_ROB_ADDR_W-1:0] issue_dep,
    input  logic                    commit_in,
    input  logic [REG_IDX_W-1:0]    commit_rd,
    input  logic [P_ROB_ADDR_W-1:0] commit_robid,
    input  logic [P_XLEN-1:0]       commit_value,
    input  logic [REG_IDX_W-1:0]    dc_rs1,
    input  logic [REG_IDX_W-1:0]    dc_rs2,
    output logic [P_XLEN-1:0]       rs1_value,
    output logic                    rs1_busy,
    output logic [P_ROB_ADDR_W-1:0] rs1_dep,
    output logic [P_XLEN-1:0]       rs2_value,
    output logic                    rs2_busy,
    output logic [P_ROB_ADDR_W-1:0] rs2_dep
);
    logic [P_XLEN-1:0]       value_q [NUM_REGS];
    logic [P_XLEN-1:0]       value_d [NUM_REGS];
    logic                    busy_q  [NUM_REGS];
    logic                    busy_d  [NUM_REGS];
    logic [P_ROB_ADDR_W-1:0] dep_q   [NUM_REGS];
    logic [P_ROB_ADDR_W-1:0] dep_d   [NUM_REGS];

    always_comb begin
        value_d = value_q;
        busy_d  = busy_q;
        dep_d   = dep_q;
        if (rdy_in) begin
            if (clear_in) begin
                // The RoB is being reset, so nothing retires or issues now.
                for (int r = 0; r < NUM_REGS; r++) begin
                    busy_d[r] = 1'b0;
                    dep_d[r]  = '0;
                end
            end else begin
                if (commit_in && commit_rd != '0) begin
                    value_d[commit_rd] = commit_value;
                    if (busy_q[commit_rd] && dep_q[commit_rd] == commit_robid) begin
                        busy_d[commit_rd] = 1'b0;
                        dep_d[commit_rd]  = '0;
                    end
                end
                // Applied after commit so a same-cycle issue keeps ownership.
                if (issue_in && issue_rd != '0) begin
                    busy_d[issue_rd] = 1'b1;
                    dep_d[issue_rd]  = issue_dep;
                end
            end
        end
        value_d[0] = '0;
        busy_d[0]  = 1'b0;
        dep_d[0]   = '0;
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            for (int r = 0; r < NUM_REGS; r++) begin
                value_q[r] <= '0;
                busy_q[r]  <= 1'b0;
                dep_q[r]   <= '0;
            end
        end else begin
            value_q <= value_d;
            busy_q  <= busy_d;
            dep_q   <= dep_d;
        end
    end

    // Two identical read ports; index 0 is rs1, index 1 is rs2.
    logic [REG_IDX_W-1:0]    rs_idx    [2];
    logic [P_XLEN-1:0]       port_value[2];
    logic                    port_busy [2];
    logic [P_ROB_ADDR_W-1:0] port_dep  [2];

    assign rs_idx[0] = dc_rs1;
    assign rs_idx[1] = dc_rs2;

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_read_port
            rf_read_port #(
                .P_XLEN       (P_XLEN),
                .P_ROB_ADDR_W (P_ROB_ADDR_W)
            ) u_port (
                .rs_i           (rs_idx[gi]),
                .reg_value_i    (value_q[rs_idx[gi]]),
                .reg_busy_i     (busy_q[rs_idx[gi]]),
                .reg_dep_i      (dep_q[rs_idx[gi]]),
                .commit_i       (commit_in),
                .clear_i        (clear_in),
                .commit_rd_i    (commit_rd),
                .commit_robid_i (commit_robid),
                .commit_value_i (commit_value),
                .value_o        (port_value[gi]),
                .busy_o         (port_busy[gi]),
                .dep_o          (port_dep[gi])
            );
        end
    endgenerate

    assign rs1_value = port_value[0];
    assign rs1_busy  = port_busy[0];
    assign rs1_dep   = port_dep[0];
    assign rs2_value = port_value[1];
    assign rs2_busy  = port_busy[1];
    assign rs2_dep   = port_dep[1];
endmodule

// File: tb/tb_rename_register_file.sv
module tb_rename_register_file;
    logic        clk_in = 1'b0;
    logic        rst_in, rdy_in, clear_in;
    logic        issue_in;
    logic [4:0]  issue_rd;
    logic [3:0]  issue_dep;
    logic        commit_in;
    logic [4:0]  commit_rd;
    logic [3:0]  commit_robid;
    logic [31:0] commit_value;
    logic [4:0]  dc_rs1, dc_rs2;
    logic [31:0] rs1_value, rs2_value;
    logic        rs1_busy, rs2_busy;
    logic [3:0]  rs1_dep, rs2_dep;

    int checks = 0;
    int errors = 0;

    rename_register_file dut (
        .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in), .clear_in(clear_in),
        .issue_in(issue_in), .issue_rd(issue_rd), .issue_dep(issue_dep),
        .commit_in(commit_in), .commit_rd(commit_rd), .commit_robid(commit_robid),
        .commit_value(commit_value), .dc_rs1(dc_rs1), .dc_rs2(dc_rs2),
        .rs1_value(rs1_value), .rs1_busy(rs1_busy), .rs1_dep(rs1_dep),
        .rs2_value(rs2_value), .rs2_busy(rs2_busy), .rs2_dep(rs2_dep)
    );

    always #5 clk_in = ~clk_in;

    // Reference model: architectural state as plain arrays.
    logic [31:0] m_val  [32];
    bit          m_busy [32];
    logic [3:0]  m_dep  [32];

    // Expected operand as {value, busy, dep}.
    function automatic logic [36:0] exp_read(input logic [4:0] rs);
        if (rs == 5'd0)
            return 37'd0;
        if (commit_in && !clear_in && rs == commit_rd && m_busy[rs] && m_dep[rs] == commit_robid)
            return {commit_value, 1'b0, 4'd0};
        if (m_busy[rs])
            return {32'd0, 1'b1, m_dep[rs]};
        return {m_val[rs], 1'b0, 4'd0};
    endfunction

    task automatic model_update();
        if (rst_in) begin
            for (int r = 0; r < 32; r++) begin
                m_val[r] = 0; m_busy[r] = 0; m_dep[r] = 0;
            end
        end else if (rdy_in) begin
            if (clear_in) begin
                for (int r = 0; r < 32; r++) begin
                    m_busy[r] = 0; m_dep[r] = 0;
                end
            end else begin
                bit owner;
                owner = commit_in && commit_rd != 0 && m_busy[commit_rd] &&
                        m_dep[commit_rd] == commit_robid;
                if (commit_in && commit_rd != 0) m_val[commit_rd] = commit_value;
                if (owner) begin m_busy[commit_rd] = 0; m_dep[commit_rd] = 0; end
                if (issue_in && issue_rd != 0) begin
                    m_busy[issue_rd] = 1; m_dep[issue_rd] = issue_dep;
                end
            end
        end
    endtask

    task automatic idle();
        rst_in = 0; rdy_in = 1; clear_in = 0;
        issue_in = 0; issue_rd = 0; issue_dep = 0;
        commit_in = 0; commit_rd = 0; commit_robid = 0; commit_value = 0;
    endtask

    task automatic tick();
        @(posedge clk_in);
        model_update();
        #1;
    endtask

    task automatic test_reset();
        idle(); rst_in = 1;
        tick(); tick();
        rst_in = 0; dc_rs1 = 5; dc_rs2 = 0;
        #1;
        checks++;
        if ({rs1_value, rs1_busy, rs1_dep} !== 37'd0) begin
            errors++; $display("FAIL reset_rs1 got %h exp %h", {rs1_value, rs1_busy, rs1_dep}, 37'd0);
        end
        checks++;
        if ({rs2_value, rs2_busy, rs2_dep} !== 37'd0) begin
            errors++; $display("FAIL reset_rs2 got %h exp %h", {rs2_value, rs2_busy, rs2_dep}, 37'd0);
        end
    endtask

    task automatic test_issue_commit();
        idle(); issue_in = 1; issue_rd = 3; issue_dep = 7;
        tick();
        idle(); dc_rs1 = 3; #1;
        checks++;
        if ({rs1_value, rs1_busy, rs1_dep} !== {32'd0, 1'b1, 4'd7}) begin
            errors++; $display("FAIL issue_busy got %h exp %h", {rs1_value, rs1_busy, rs1_dep}, {32'd0, 1'b1, 4'd7});
        end
        commit_in = 1; commit_rd = 3; commit_robid = 7; commit_value = 32'hDEADBEEF; #1;
        checks++;
        if ({rs1_value, rs1_busy, rs1_dep} !== {32'hDEADBEEF, 1'b0, 4'd0}) begin
            errors++; $display("FAIL commit_bypass got %h exp %h", {rs1_value, rs1_busy, rs1_dep}, {32'hDEADBEEF, 1'b0, 4'd0});
        end
        tick();
        idle(); #1;
        checks++;
        if ({rs1_value, rs1_busy, rs1_dep} !== {32'hDEADBEEF, 1'b0, 4'd0}) begin
            errors++; $display("FAIL commit_stored got %h exp %h", {rs1_value, rs1_busy, rs1_dep}, {32'hDEADBEEF, 1'b0, 4'd0});
        end
    endtask

    task automatic test_stale_commit();
        idle(); issue_in = 1; issue_rd = 4; issue_dep = 2; tick();
        issue_dep = 5; tick();
        idle(); commit_in = 1; commit_rd = 4; commit_robid = 2; commit_value = 32'h11; dc_rs1 = 4; #1;
        checks++;
        if ({rs1_value, rs1_busy, rs1_dep} !== {32'd0, 1'b1, 4'd5}) begin
            errors++; $display("FAIL stale_no_bypass got %h exp %h", {rs1_value, rs1_busy, rs1_dep}, {32'd0, 1'b1, 4'd5});
        end
        tick();
        idle(); #1;
        checks++;
        if ({rs1_value, rs1_busy, rs1_dep} !== {32'd0, 1'b1, 4'd5}) begin
            errors++; $display("FAIL stale_still_busy got %h exp %h", {rs1_value, rs1_busy, rs1_dep}, {32'd0, 1'b1, 4'd5});
        end
        // Flushing exposes the value that the stale commit wrote underneath.
        clear_in = 1; tick();
        idle(); #1;
        checks++;
        if ({rs1_value, rs1_busy, rs1_dep} !== {32'h11, 1'b0, 4'd0}) begin
            errors++; $display("FAIL stale_value got %h exp %h", {rs1_value, rs1_busy, rs1_dep}, {32'h11, 1'b0, 4'd0});
        end
    endtask

    task automatic test_same_cycle();
        idle(); issue_in = 1; issue_rd = 6; issue_dep = 1; tick();
        idle(); issue_in = 1; issue_rd = 6; issue_dep = 9;
        commit_in = 1; commit_rd = 6; commit_robid = 1; commit_value = 32'h22; dc_rs2 = 6; #1;
        checks++;
        if ({rs2_value, rs2_busy, rs2_dep} !== {32'h22, 1'b0, 4'd0}) begin
            errors++; $display("FAIL same_cycle_bypass got %h exp %h", {rs2_value, rs2_busy, rs2_dep}, {32'h22, 1'b0, 4'd0});
        end
        tick();
        idle(); #1;
        checks++;
        if ({rs2_value, rs2_busy, rs2_dep} !== {32'd0, 1'b1, 4'd9}) begin
            errors++; $display("FAIL same_cycle_owner got %h exp %h", {rs2_value, rs2_busy, rs2_dep}, {32'd0, 1'b1, 4'd9});
        end
        clear_in = 1; tick();
        idle(); #1;
        checks++;
        if ({rs2_value, rs2_busy, rs2_dep} !== {32'h22, 1'b0, 4'd0}) begin
            errors++; $display("FAIL same_cycle_value got %h exp %h", {rs2_value, rs2_busy, rs2_dep}, {32'h22, 1'b0, 4'd0});
        end
    endtask

    task automatic make_busy();
        idle(); issue_in = 1;
        issue_rd = 1;  issue_dep = 3; tick();
        issue_rd = 2;  issue_dep = 4; tick();
        issue_rd = 31; issue_dep = 5; tick();
        idle();
    endtask

    task automatic test_flush();
        logic [31:0] old1;
        make_busy();
        old1 = m_val[1];
        clear_in = 1; commit_in = 1; commit_rd = 1; commit_robid = 3; commit_value = 32'h33;
        dc_rs1 = 1; dc_rs2 = 31; #1;
        checks++;
        if ({rs1_value, rs1_busy, rs1_dep} !== {32'd0, 1'b1, 4'd3}) begin
            errors++; $display("FAIL flush_no_bypass got %h exp %h", {rs1_value, rs1_busy, rs1_dep}, {32'd0, 1'b1, 4'd3});
        end
        tick();
        idle(); #1;
        checks++;
        if ({rs1_value, rs1_busy, rs1_dep} !== {old1, 1'b0, 4'd0}) begin
            errors++; $display("FAIL flush_r1 got %h exp %h", {rs1_value, rs1_busy, rs1_dep}, {old1, 1'b0, 4'd0});
        end
        checks++;
        if ({rs2_value, rs2_busy, rs2_dep} !== {m_val[31], 1'b0, 4'd0}) begin
            errors++; $display("FAIL flush_r31 got %h exp %h", {rs2_value, rs2_busy, rs2_dep}, {m_val[31], 1'b0, 4'd0});
        end
        dc_rs1 = 2; #1;
        checks++;
        if (rs1_busy !== 1'b0) begin
            errors++; $display("FAIL flush_r2 got busy %b exp 0", rs1_busy);
        end
    endtask

    task automatic test_rdy_low();
        make_busy();
        rdy_in = 0; clear_in = 1; commit_in = 1; commit_rd = 1; commit_robid = 3; commit_value = 32'h33;
        tick();
        rdy_in = 0; clear_in = 0; commit_in = 0; issue_in = 1; issue_rd = 2; issue_dep = 12;
        tick();
        idle(); dc_rs1 = 1; dc_rs2 = 2; #1;
        checks++;
        if ({rs1_value, rs1_busy, rs1_dep} !== {32'd0, 1'b1, 4'd3}) begin
            errors++; $display("FAIL rdy_low_r1 got %h exp %h", {rs1_value, rs1_busy, rs1_dep}, {32'd0, 1'b1, 4'd3});
        end
        checks++;
        if ({rs2_value, rs2_busy, rs2_dep} !== {32'd0, 1'b1, 4'd4}) begin
            errors++; $display("FAIL rdy_low_r2 got %h exp %h", {rs2_value, rs2_busy, rs2_dep}, {32'd0, 1'b1, 4'd4});
        end
        dc_rs2 = 31; #1;
        checks++;
        if ({rs2_value, rs2_busy, rs2_dep} !== {32'd0, 1'b1, 4'd5}) begin
            errors++; $display("FAIL rdy_low_r31 got %h exp %h", {rs2_value, rs2_busy, rs2_dep}, {32'd0, 1'b1, 4'd5});
        end
        clear_in = 1; tick(); idle();
    endtask

    task automatic test_x0();
        idle(); issue_in = 1; issue_rd = 0; issue_dep = 3;
        commit_in = 1; commit_rd = 0; commit_robid = 3; commit_value = 32'hFF;
        dc_rs1 = 0; dc_rs2 = 0; #1;
        checks++;
        if ({rs1_value, rs1_busy, rs1_dep} !== 37'd0) begin
            errors++; $display("FAIL x0_same_cycle got %h exp %h", {rs1_value, rs1_busy, rs1_dep}, 37'd0);
        end
        tick();
        idle(); #1;
        checks++;
        if ({rs2_value, rs2_busy, rs2_dep} !== 37'd0) begin
            errors++; $display("FAIL x0_after got %h exp %h", {rs2_value, rs2_busy, rs2_dep}, 37'd0);
        end
    endtask

    task automatic test_random();
        logic [36:0] e1, e2;
        for (int n = 0; n < 400; n++) begin
            idle();
            rdy_in    = ($urandom_range(0, 9) != 0);
            clear_in  = ($urandom_range(0, 24) == 0);
            issue_in  = $urandom_range(0, 1);
            issue_rd  = 5'($urandom_range(0, 7));
            issue_dep = 4'($urandom);
            commit_in = $urandom_range(0, 1);
            commit_rd = 5'($urandom_range(0, 7));
            commit_robid = (m_busy[commit_rd] && $urandom_range(0, 3) != 0) ? m_dep[commit_rd] : 4'($urandom);
            commit_value = $urandom;
            dc_rs1 = ($urandom_range(0, 1) != 0) ? commit_rd : 5'($urandom_range(0, 7));
            dc_rs2 = 5'($urandom_range(0, 7));
            #1;
            e1 = exp_read(dc_rs1);
            e2 = exp_read(dc_rs2);
            checks++;
            if ({rs1_value, rs1_busy, rs1_dep} !== e1) begin
                errors++; $display("FAIL rand_rs1 n=%0d rs=%0d got %h exp %h", n, dc_rs1, {rs1_value, rs1_busy, rs1_dep}, e1);
            end
            checks++;
            if ({rs2_value, rs2_busy, rs2_dep} !== e2) begin
                errors++; $display("FAIL rand_rs2 n=%0d rs=%0d got %h exp %h", n, dc_rs2, {rs2_value, rs2_busy, rs2_dep}, e2);
            end
            tick();
        end
        idle();
    endtask

    initial begin
        idle(); dc_rs1 = 0; dc_rs2 = 0;
        test_reset();
        test_issue_commit();
        test_stale_commit();
        test_same_cycle();
        test_flush();
        test_rdy_low();
        test_x0();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
